// File: rtl/id_ex_if.sv
// ============================================================================
// id_ex_if : decode-side, hazard-control, forwarding and EX-facing signals
//            of the ID/EX pipeline register.
// Rev 1.0
// ============================================================================
`default_nettype none

interface id_ex_if;
  logic        id_valid;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src;
  logic        id_reg_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        stall;
  logic        flush;
  logic        exmem_reg_write;
  logic        memwb_reg_write;
  logic [4:0]  exmem_rd;
  logic [4:0]  memwb_rd;
  logic [31:0] exmem_result;
  logic [31:0] memwb_result;
  logic        ex_valid;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_store_data;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        hazard_stall;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_ctrl, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
           id_mem_write, stall, flush, exmem_reg_write, memwb_reg_write,
           exmem_rd, memwb_rd, exmem_result, memwb_result,
    input  ex_valid, ex_a, ex_b, ex_store_data, ex_alu_ctrl, ex_dest,
           ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_alu_ctrl, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
           id_mem_write, stall, flush, exmem_reg_write, memwb_reg_write,
           exmem_rd, memwb_rd, exmem_result, memwb_result,
    output ex_valid, ex_a, ex_b, ex_store_data, ex_alu_ctrl, ex_dest,
           ex_reg_write, ex_mem_read, ex_mem_write, hazard_stall
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_reg.sv
// ============================================================================
// id_ex_reg : ID/EX pipeline register with load-use hazard detection and
//             EX/MEM, MEM/WB operand forwarding.
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_reg (
  input wire logic   clk,
  input wire logic   rst_n,
  id_ex_if.slave     bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;
  stage_t load_w;
  logic   hazard_w;

  // EX/MEM is the younger result, so it is checked first; index 0 is never forwarded.
  function automatic logic [31:0] fwd(
    input logic [31:0] x,
    input logic [4:0]  idx,
    input logic        em_we,
    input logic [4:0]  em_rd,
    input logic [31:0] em_res,
    input logic        mw_we,
    input logic [4:0]  mw_rd,
    input logic [31:0] mw_res
  );
    if (em_we && (em_rd != 5'd0) && (em_rd == idx))      return em_res;
    else if (mw_we && (mw_rd != 5'd0) && (mw_rd == idx)) return mw_res;
    else                                                 return x;
  endfunction

  always_comb begin
    hazard_w = bus.id_valid & stage_q.valid & stage_q.mem_read &
               (stage_q.dest != 5'd0) &
               ((stage_q.dest == bus.id_rs) | (stage_q.dest == bus.id_rt));
  end

  always_comb begin
    load_w           = '0;
    load_w.valid     = bus.id_valid;
    load_w.rs_data   = bus.id_rs_data;
    load_w.rt_data   = bus.id_rt_data;
    load_w.imm       = bus.id_imm;
    load_w.rs        = bus.id_rs;
    load_w.rt        = bus.id_rt;
    load_w.dest      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    load_w.alu_ctrl  = bus.id_alu_ctrl;
    load_w.alu_src   = bus.id_alu_src;
    // Side-effecting controls are suppressed for an invalid slot.
    load_w.reg_write = bus.id_reg_write & bus.id_valid;
    load_w.mem_read  = bus.id_mem_read  & bus.id_valid;
    load_w.mem_write = bus.id_mem_write & bus.id_valid;
  end

  always_comb begin
    stage_d = stage_q;
    if (bus.flush)      stage_d = '0;
    else if (bus.stall) stage_d = stage_q;
    else if (hazard_w)  stage_d = '0;
    else                stage_d = load_w;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  always_comb begin
    fwd_rs = fwd(stage_q.rs_data, stage_q.rs,
                 bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                 bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
    fwd_rt = fwd(stage_q.rt_data, stage_q.rt,
                 bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                 bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
  end

  assign bus.ex_a          = fwd_rs;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_b          = stage_q.alu_src ? stage_q.imm : fwd_rt;
  assign bus.ex_valid      = stage_q.valid;
  assign bus.ex_alu_ctrl   = stage_q.alu_ctrl;
  assign bus.ex_dest       = stage_q.dest;
  assign bus.ex_reg_write  = stage_q.reg_write;
  assign bus.ex_mem_read   = stage_q.mem_read;
  assign bus.ex_mem_write  = stage_q.mem_write;
  assign bus.hazard_stall  = hazard_w;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// ============================================================================
// tb_id_ex_reg : directed self-checking bench for id_ex_reg.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_reg;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  id_ex_if bus ();

  id_ex_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    bus.id_valid     = 1'b0;
    bus.id_rs_data   = '0;
    bus.id_rt_data   = '0;
    bus.id_imm       = '0;
    bus.id_rs        = '0;
    bus.id_rt        = '0;
    bus.id_rd        = '0;
    bus.id_alu_ctrl  = '0;
    bus.id_alu_src   = 1'b0;
    bus.id_reg_dst   = 1'b0;
    bus.id_reg_write = 1'b0;
    bus.id_mem_read  = 1'b0;
    bus.id_mem_write = 1'b0;
  endtask

  task automatic clr_fwd();
    bus.exmem_reg_write = 1'b0;
    bus.memwb_reg_write = 1'b0;
    bus.exmem_rd        = '0;
    bus.memwb_rd        = '0;
    bus.exmem_result    = '0;
    bus.memwb_result    = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.stall   = 1'b0;
    bus.flush   = 1'b0;
    clr_id();
    clr_fwd();

    // Reset state
    edge_step();
    edge_step();
    chk("rst_valid",  32'(bus.ex_valid), 32'd0);
    chk("rst_dest",   32'(bus.ex_dest), 32'd0);
    chk("rst_ctrl",   32'(bus.ex_alu_ctrl), 32'd0);
    chk("rst_a",      bus.ex_a, 32'd0);
    chk("rst_hazard", 32'(bus.hazard_stall), 32'd0);
    rst_n = 1'b1;

    // Plain load, reg_dst selects rd
    bus.id_valid = 1'b1; bus.id_rs_data = 32'd10; bus.id_rt_data = 32'd20;
    bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_rd = 5'd3;
    bus.id_alu_ctrl = 4'b0010; bus.id_reg_dst = 1'b1; bus.id_reg_write = 1'b1;
    edge_step();
    chk("ld_a",     bus.ex_a, 32'd10);
    chk("ld_b",     bus.ex_b, 32'd20);
    chk("ld_sd",    bus.ex_store_data, 32'd20);
    chk("ld_ctrl",  32'(bus.ex_alu_ctrl), 32'h2);
    chk("ld_dest",  32'(bus.ex_dest), 32'd3);
    chk("ld_valid", 32'(bus.ex_valid), 32'd1);
    chk("ld_rw",    32'(bus.ex_reg_write), 32'd1);

    // Forwarding priority on a held instruction
    clr_id();
    bus.id_valid = 1'b1; bus.id_rs = 5'd5; bus.id_rs_data = 32'd11;
    bus.id_rt = 5'd6; bus.id_rt_data = 32'd22;
    edge_step();
    bus.stall = 1'b1;
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'd50;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'd99;
    #1;
    chk("fwd_exmem", bus.ex_a, 32'd50);
    chk("fwd_rt_nomatch", bus.ex_store_data, 32'd22);
    bus.exmem_reg_write = 1'b0;
    #1;
    chk("fwd_memwb", bus.ex_a, 32'd99);
    bus.exmem_rd = 5'd0; bus.memwb_rd = 5'd0; bus.exmem_reg_write = 1'b1;
    #1;
    chk("fwd_none", bus.ex_a, 32'd11);
    bus.memwb_rd = 5'd6;
    #1;
    chk("fwd_rt_sd", bus.ex_store_data, 32'd99);
    chk("fwd_rt_b",  bus.ex_b, 32'd99);
    edge_step();
    chk("stall_hold_a", bus.ex_a, 32'd11);
    bus.stall = 1'b0;
    clr_fwd();

    // Immediate selects ex_b while store data still forwards; index 0 not forwarded
    clr_id();
    bus.id_valid = 1'b1; bus.id_alu_src = 1'b1; bus.id_imm = 32'hFFFF_FFF6;
    bus.id_rt = 5'd4; bus.id_rt_data = 32'd8; bus.id_rs = 5'd0; bus.id_rs_data = 32'd5;
    edge_step();
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd4; bus.exmem_result = 32'h1234;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'd77;
    #1;
    chk("imm_b",  bus.ex_b, 32'hFFFF_FFF6);
    chk("imm_sd", bus.ex_store_data, 32'h1234);
    chk("idx0_a", bus.ex_a, 32'd5);
    clr_fwd();

    // Load-use hazard
    clr_id();
    bus.id_valid = 1'b1; bus.id_mem_read = 1'b1; bus.id_reg_write = 1'b1;
    bus.id_rt = 5'd7; bus.id_reg_dst = 1'b0;
    edge_step();
    clr_id();
    bus.id_valid = 1'b1; bus.id_rs = 5'd1; bus.id_rt = 5'd7; bus.id_rd = 5'd9;
    bus.id_reg_dst = 1'b1; bus.id_rs_data = 32'd33; bus.id_rt_data = 32'd44;
    bus.id_reg_write = 1'b1;
    #1;
    chk("hz_assert", 32'(bus.hazard_stall), 32'd1);
    edge_step();
    chk("hz_bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("hz_bubble_rw",    32'(bus.ex_reg_write), 32'd0);
    chk("hz_bubble_mr",    32'(bus.ex_mem_read), 32'd0);
    chk("hz_bubble_dest",  32'(bus.ex_dest), 32'd0);
    chk("hz_release",      32'(bus.hazard_stall), 32'd0);
    edge_step();
    chk("hz_load_valid", 32'(bus.ex_valid), 32'd1);
    chk("hz_load_dest",  32'(bus.ex_dest), 32'd9);
    chk("hz_load_a",     bus.ex_a, 32'd33);

    // Load to r0 never raises a hazard
    clr_id();
    bus.id_valid = 1'b1; bus.id_mem_read = 1'b1; bus.id_rt = 5'd0;
    edge_step();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_mem_read = 1'b0;
    #1;
    chk("hz_r0", 32'(bus.hazard_stall), 32'd0);

    // Stall for three cycles then flush under stall
    clr_id();
    bus.id_valid = 1'b1; bus.id_alu_ctrl = 4'b0110; bus.id_reg_dst = 1'b1;
    bus.id_rd = 5'd12; bus.id_rs_data = 32'hAA; bus.id_reg_write = 1'b1;
    edge_step();
    bus.stall = 1'b1;
    bus.id_rd = 5'd20; bus.id_alu_ctrl = 4'b1111; bus.id_rs_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk("stall_valid", 32'(bus.ex_valid), 32'd1);
      chk("stall_dest",  32'(bus.ex_dest), 32'd12);
      chk("stall_ctrl",  32'(bus.ex_alu_ctrl), 32'h6);
      chk("stall_a",     bus.ex_a, 32'hAA);
    end
    bus.flush = 1'b1;
    edge_step();
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_dest",  32'(bus.ex_dest), 32'd0);
    chk("flush_rw",    32'(bus.ex_reg_write), 32'd0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Reset during a held stall discards the held load
    clr_id();
    bus.id_valid = 1'b1; bus.id_mem_read = 1'b1; bus.id_reg_dst = 1'b1;
    bus.id_rd = 5'd8; bus.id_alu_ctrl = 4'b0010;
    edge_step();
    bus.stall = 1'b1;
    bus.id_rs = 5'd8; bus.id_mem_read = 1'b0;
    #1;
    chk("pre_rst_hazard", 32'(bus.hazard_stall), 32'd1);
    rst_n = 1'b0;
    edge_step();
    chk("rst_stall_valid",  32'(bus.ex_valid), 32'd0);
    chk("rst_stall_dest",   32'(bus.ex_dest), 32'd0);
    chk("rst_stall_ctrl",   32'(bus.ex_alu_ctrl), 32'd0);
    chk("rst_stall_hazard", 32'(bus.hazard_stall), 32'd0);
    rst_n = 1'b1;
    bus.stall = 1'b0;

    // Invalid slot suppresses side-effecting controls
    clr_id();
    bus.id_valid = 1'b0; bus.id_reg_write = 1'b1; bus.id_mem_write = 1'b1;
    bus.id_mem_read = 1'b1; bus.id_rt = 5'd14;
    edge_step();
    chk("inv_valid", 32'(bus.ex_valid), 32'd0);
    chk("inv_rw",    32'(bus.ex_reg_write), 32'd0);
    chk("inv_mw",    32'(bus.ex_mem_write), 32'd0);
    chk("inv_mr",    32'(bus.ex_mem_read), 32'd0);
    chk("inv_dest",  32'(bus.ex_dest), 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
